// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller: latches hall/car requests, travels SCAN-style,
// reverses at the current floor, supports door hold/reopen and an arrival strobe.
module elevator_ctrl_n #(
  parameter int N_FLOORS    = 8,
  parameter int MOVE_CYCLES = 10,
  parameter int DOOR_CYCLES = 10,
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] hall_up_req,
  input  logic [N_FLOORS-1:0] hall_dn_req,
  input  logic [N_FLOORS-1:0] car_req,
  input  logic                door_hold,
  output logic [FW-1:0]       floor,
  output logic [1:0]          direction,
  output logic                door_open,
  output logic                moving,
  output logic                arrive,
  output logic [N_FLOORS-1:0] hall_up_pend,
  output logic [N_FLOORS-1:0] hall_dn_pend,
  output logic [N_FLOORS-1:0] car_pend
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [N_FLOORS-1:0] ONE     = {{(N_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR} state_t;

  state_t              state, state_d;
  logic [TW-1:0]       timer, timer_d;
  logic [FW-1:0]       floor_d, step_floor;
  logic [1:0]          dir_d, dir_rev;
  logic                arrive_d;
  logic [N_FLOORS-1:0] up_in, dn_in, all_pend, here, at_g;
  logic [N_FLOORS-1:0] fwd_hall, rev_hall;
  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic                above, below, beyond_g, fwd_any, rev_any;
  logic                timer_done, absorb, stop_req, rev_at_g;

  assign up_in      = hall_up_req & UP_MASK;
  assign dn_in      = hall_dn_req & DN_MASK;
  assign all_pend   = hall_up_pend | hall_dn_pend | car_pend;
  assign here       = ONE << floor;
  assign step_floor = (direction == DIR_DN) ? floor - FW'(1) : floor + FW'(1);
  assign at_g       = ONE << step_floor;
  assign timer_done = (timer <= TW'(1));
  assign dir_rev    = (direction == DIR_UP) ? DIR_DN : DIR_UP;
  assign fwd_hall   = (direction == DIR_DN) ? hall_dn_pend : hall_up_pend;
  assign rev_hall   = (direction == DIR_DN) ? hall_up_pend : hall_dn_pend;
  assign fwd_any    = (direction == DIR_UP) ? above : (direction == DIR_DN) ? below : 1'b0;
  assign rev_any    = (direction == DIR_UP) ? below : (direction == DIR_DN) ? above : 1'b0;
  assign stop_req   = |((car_pend | fwd_hall) & at_g);
  assign rev_at_g   = |(rev_hall & at_g);

  // A fresh request for the floor being served while the door is open
  assign absorb = |(here & (car_req
                          | ((direction == DIR_UP) ? up_in : '0)
                          | ((direction == DIR_DN) ? dn_in : '0)));

  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    beyond_g = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor)) above = above | all_pend[i];
      if (i < int'(floor)) below = below | all_pend[i];
      if (direction == DIR_UP && i > int'(step_floor)) beyond_g = beyond_g | all_pend[i];
      if (direction == DIR_DN && i < int'(step_floor)) beyond_g = beyond_g | all_pend[i];
    end
  end

  always_comb begin
    state_d  = state;
    floor_d  = floor;
    dir_d    = direction;
    timer_d  = timer;
    arrive_d = 1'b0;
    clr_up   = '0;
    clr_dn   = '0;
    clr_car  = '0;
    case (state)
      S_IDLE: begin
        if (|(all_pend & here)) begin
          state_d = S_DOOR;
          timer_d = TW'(DOOR_CYCLES);
          clr_car = here;
          if (|(hall_up_pend & here)) begin
            dir_d  = DIR_UP;
            clr_up = here;
          end else if (|(hall_dn_pend & here)) begin
            dir_d  = DIR_DN;
            clr_dn = here;
          end else begin
            dir_d = DIR_NONE;
          end
        end else if (above) begin
          state_d = S_MOVING;
          dir_d   = DIR_UP;
          timer_d = TW'(MOVE_CYCLES);
        end else if (below) begin
          state_d = S_MOVING;
          dir_d   = DIR_DN;
          timer_d = TW'(MOVE_CYCLES);
        end
      end
      S_MOVING: begin
        if (!timer_done) begin
          timer_d = timer - TW'(1);
        end else begin
          floor_d = step_floor;
          if (stop_req || !beyond_g) begin
            state_d  = S_DOOR;
            timer_d  = TW'(DOOR_CYCLES);
            arrive_d = 1'b1;
            clr_car  = at_g;
            // End of the sweep with only a waiting opposite-direction passenger
            if (!stop_req && rev_at_g) dir_d = dir_rev;
            if (dir_d == DIR_UP) clr_up = at_g;
            else                 clr_dn = at_g;
          end else begin
            timer_d = TW'(MOVE_CYCLES);
          end
        end
      end
      S_DOOR: begin
        clr_car = here;
        if (direction == DIR_UP) clr_up = here;
        if (direction == DIR_DN) clr_dn = here;
        if (door_hold || absorb) begin
          timer_d = TW'(DOOR_CYCLES);
        end else if (!timer_done) begin
          timer_d = timer - TW'(1);
        end else if (direction == DIR_NONE) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (fwd_any) begin
          state_d = S_MOVING;
          timer_d = TW'(MOVE_CYCLES);
        end else if (|(rev_hall & here)) begin
          dir_d   = dir_rev;
          timer_d = TW'(DOOR_CYCLES);
          if (dir_rev == DIR_UP) clr_up = here;
          else                   clr_dn = here;
        end else if (rev_any) begin
          dir_d   = dir_rev;
          state_d = S_MOVING;
          timer_d = TW'(MOVE_CYCLES);
        end else begin
          dir_d   = DIR_NONE;
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      floor        <= '0;
      direction    <= DIR_NONE;
      door_open    <= 1'b0;
      moving       <= 1'b0;
      arrive       <= 1'b0;
      hall_up_pend <= '0;
      hall_dn_pend <= '0;
      car_pend     <= '0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      floor        <= floor_d;
      direction    <= dir_d;
      door_open    <= (state_d == S_DOOR);
      moving       <= (state_d == S_MOVING);
      arrive       <= arrive_d;
      hall_up_pend <= (hall_up_pend | up_in) & ~clr_up;
      hall_dn_pend <= (hall_dn_pend | dn_in) & ~clr_dn;
      car_pend     <= (car_pend | car_req) & ~clr_car;
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: directed scenarios plus random traffic, every cycle
// compared against a deadline-based reference model of the car.
module tb_elevator_ctrl_n;
  localparam int N = 8;
  localparam int M = 10;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] hall_up_req = '0, hall_dn_req = '0, car_req = '0;
  logic         door_hold = 1'b0;
  logic [2:0]   floor;
  logic [1:0]   direction;
  logic         door_open, moving, arrive;
  logic [N-1:0] hall_up_pend, hall_dn_pend, car_pend;

  elevator_ctrl_n #(.N_FLOORS(N), .MOVE_CYCLES(M), .DOOR_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req), .car_req(car_req),
    .door_hold(door_hold),
    .floor(floor), .direction(direction), .door_open(door_open), .moving(moving),
    .arrive(arrive), .hall_up_pend(hall_up_pend), .hall_dn_pend(hall_dn_pend),
    .car_pend(car_pend)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int prev_floor = 0;

  // Reference model: absolute-cycle deadlines, floors as ints, direction as +1/-1/0
  bit m_up [N];
  bit m_dn [N];
  bit m_car [N];
  int m_floor = 0, m_dir = 0, m_deadline = 0, cyc = 0;
  bit m_door = 0, m_move = 0, m_arrive = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit any_in(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < N && (m_up[i] || m_dn[i] || m_car[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_ahead(input int from, input int dir);
    if (dir > 0) return any_in(from + 1, N - 1);
    if (dir < 0) return any_in(0, from - 1);
    return 1'b0;
  endfunction

  function automatic bit hall_toward(input int fl, input int dir);
    if (dir > 0) return m_up[fl];
    if (dir < 0) return m_dn[fl];
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] u, input logic [N-1:0] d,
                            input logic [N-1:0] c, input logic h);
    bit sv_up [N];
    bit sv_dn [N];
    bit sv_car [N];
    int f, g;
    cyc++;
    m_arrive = 0;
    if (r) begin
      m_floor = 0; m_dir = 0; m_door = 0; m_move = 0;
      for (int i = 0; i < N; i++) begin m_up[i] = 0; m_dn[i] = 0; m_car[i] = 0; end
      return;
    end
    for (int i = 0; i < N; i++) begin sv_up[i] = 0; sv_dn[i] = 0; sv_car[i] = 0; end
    f = m_floor;
    if (m_move) begin
      if (cyc == m_deadline) begin
        g = f + m_dir;
        m_floor = g;
        if (m_car[g] || hall_toward(g, m_dir) || !any_ahead(g, m_dir)) begin
          m_move = 0; m_door = 1; m_arrive = 1; m_deadline = cyc + D;
          sv_car[g] = 1;
          if (!m_car[g] && !hall_toward(g, m_dir) && hall_toward(g, -m_dir)) m_dir = -m_dir;
          if (m_dir > 0) sv_up[g] = 1; else sv_dn[g] = 1;
        end else begin
          m_deadline = cyc + M;
        end
      end
    end else if (m_door) begin
      sv_car[f] = 1;
      if (m_dir > 0) sv_up[f] = 1;
      if (m_dir < 0) sv_dn[f] = 1;
      if (h || c[f] || (m_dir > 0 && u[f] && f != N - 1) || (m_dir < 0 && d[f] && f != 0)) begin
        m_deadline = cyc + D;
      end else if (cyc == m_deadline) begin
        if (m_dir != 0 && any_ahead(f, m_dir)) begin
          m_door = 0; m_move = 1; m_deadline = cyc + M;
        end else if (m_dir != 0 && hall_toward(f, -m_dir)) begin
          m_dir = -m_dir; m_deadline = cyc + D;
          if (m_dir > 0) sv_up[f] = 1; else sv_dn[f] = 1;
        end else if (m_dir != 0 && any_ahead(f, -m_dir)) begin
          m_dir = -m_dir; m_door = 0; m_move = 1; m_deadline = cyc + M;
        end else begin
          m_dir = 0; m_door = 0;
        end
      end
    end else begin
      if (m_up[f] || m_dn[f] || m_car[f]) begin
        m_door = 1; m_deadline = cyc + D; sv_car[f] = 1;
        if (m_up[f]) begin m_dir = 1; sv_up[f] = 1; end
        else if (m_dn[f]) begin m_dir = -1; sv_dn[f] = 1; end
        else m_dir = 0;
      end else if (any_in(f + 1, N - 1)) begin
        m_dir = 1; m_move = 1; m_deadline = cyc + M;
      end else if (any_in(0, f - 1)) begin
        m_dir = -1; m_move = 1; m_deadline = cyc + M;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_up[i]  = (m_up[i]  || (u[i] && i != N - 1)) && !sv_up[i];
      m_dn[i]  = (m_dn[i]  || (d[i] && i != 0))     && !sv_dn[i];
      m_car[i] = (m_car[i] || c[i]) && !sv_car[i];
    end
  endtask

  task automatic check_all(input logic r);
    logic [N-1:0] eu, ed, ec;
    logic [1:0]   edir;
    for (int i = 0; i < N; i++) begin eu[i] = m_up[i]; ed[i] = m_dn[i]; ec[i] = m_car[i]; end
    edir = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
    chk("floor", 32'(floor), 32'(m_floor));
    chk("direction", 32'(direction), 32'(edir));
    chk("door_open", 32'(door_open), 32'(m_door));
    chk("moving", 32'(moving), 32'(m_move));
    chk("arrive", 32'(arrive), 32'(m_arrive));
    chk("hall_up_pend", 32'(hall_up_pend), 32'(eu));
    chk("hall_dn_pend", 32'(hall_dn_pend), 32'(ed));
    chk("car_pend", 32'(car_pend), 32'(ec));
    if (!r)
      chk("floor_range", 32'((int'(floor) - prev_floor <= 1) && (prev_floor - int'(floor) <= 1)
                             && int'(floor) < N), 32'd1);
    prev_floor = int'(floor);
  endtask

  task automatic step(input logic r, input logic [N-1:0] u, input logic [N-1:0] d,
                      input logic [N-1:0] c, input logic h);
    @(negedge clk);
    reset = r; hall_up_req = u; hall_dn_req = d; car_req = c; door_hold = h;
    @(posedge clk);
    model_step(r, u, d, c, h);
    #1;
    check_all(r);
  endtask

  logic [N-1:0] ru, rd, rc;
  logic         rh, rr;
  int           hold_left;

  initial begin
    // Reset held for several cycles
    for (int k = 0; k < 3; k++) begin
      step(1'b1, '0, '0, '0, 1'b0);
      chk("rst_floor", 32'(floor), 32'd0);
      chk("rst_dir", 32'(direction), 32'd0);
      chk("rst_door", 32'(door_open), 32'd0);
      chk("rst_moving", 32'(moving), 32'd0);
      chk("rst_pend", 32'(hall_up_pend | hall_dn_pend | car_pend), 32'd0);
    end
    step(1'b0, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);

    // Car call to floor 3 from floor 0
    for (int k = 0; k <= 42; k++) begin
      step(1'b0, '0, '0, (k == 0) ? 8'h08 : 8'h00, 1'b0);
      if (k == 0)  chk("t1_latch", 32'(car_pend[3]), 32'd1);
      if (k == 1)  chk("t1_moving", 32'({moving, direction}), 32'b101);
      if (k == 10) chk("t1_f0", 32'(floor), 32'd0);
      if (k == 11) chk("t1_f1", 32'(floor), 32'd1);
      if (k == 21) chk("t1_f2", 32'(floor), 32'd2);
      if (k == 31) chk("t1_arrive", 32'({floor, arrive, door_open}), 32'b01111);
      if (k == 32) chk("t1_strobe", 32'(arrive), 32'd0);
      if (k == 40) chk("t1_door_hold", 32'(door_open), 32'd1);
      if (k == 41) chk("t1_closed", 32'({door_open, direction, car_pend}), 32'd0);
    end

    // Hall down at 5 plus car call at 2, from floor 0
    step(1'b1, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k <= 75; k++) begin
      step(1'b0, '0, (k == 0) ? 8'h20 : 8'h00, (k == 0) ? 8'h04 : 8'h00, 1'b0);
      if (k == 21) chk("t2_stop2", 32'({floor, arrive}), 32'b0101);
      if (k == 30) chk("t2_door2", 32'(door_open), 32'd1);
      if (k == 31) chk("t2_leave2", 32'({moving, door_open}), 32'b10);
      if (k == 61) chk("t2_stop5", 32'({floor, arrive, direction}), 32'b101110);
      if (k == 61) chk("t2_dn5_clr", 32'(hall_dn_pend), 32'd0);
      if (k == 71) chk("t2_idle", 32'({door_open, direction}), 32'd0);
    end

    // Door hold and same-floor reopen at floor 3
    for (int k = 0; k <= 62; k++) begin
      step(1'b0, '0, '0, (k == 0 || k == 30 || k == 50) ? 8'h08 : 8'h00, (k >= 22 && k <= 46));
      if (k == 21) chk("t3_arrive3", 32'({floor, door_open}), 32'b0111);
      if (k == 30) chk("t3_absorb_hold", 32'({car_pend, door_open}), 32'd1);
      if (k == 50) chk("t3_absorb", 32'(car_pend), 32'd0);
      if (k == 56) chk("t3_reopened", 32'(door_open), 32'd1);
      if (k == 59) chk("t3_still_open", 32'(door_open), 32'd1);
      if (k == 60) chk("t3_closed", 32'(door_open), 32'd0);
    end

    // Up and down hall calls together at floor 1
    for (int k = 0; k <= 33; k++) begin
      step(1'b0, '0, '0, (k == 0) ? 8'h02 : 8'h00, 1'b0);
      if (k == 21) chk("t4_at1", 32'({floor, arrive}), 32'b0011);
    end
    for (int k = 0; k <= 22; k++) begin
      step(1'b0, (k == 0) ? 8'h02 : 8'h00, (k == 0) ? 8'h02 : 8'h00, '0, 1'b0);
      if (k == 0)  chk("t4_latch", 32'({hall_up_pend[1], hall_dn_pend[1]}), 32'b11);
      if (k == 1)  chk("t4_up_first", 32'({door_open, direction, hall_up_pend[1], hall_dn_pend[1]}), 32'b10101);
      if (k == 10) chk("t4_up_phase", 32'({door_open, direction}), 32'b101);
      if (k == 11) chk("t4_flip", 32'({door_open, direction, hall_dn_pend[1]}), 32'b1100);
      if (k == 20) chk("t4_open20", 32'(door_open), 32'd1);
      if (k == 21) chk("t4_idle", 32'({door_open, direction}), 32'd0);
    end

    // Reset while travelling between floors 2 and 3
    for (int k = 0; k <= 15; k++) begin
      step(k == 15, '0, (k == 5) ? 8'h40 : 8'h00, (k == 0) ? 8'h20 : 8'h00, 1'b0);
      if (k == 14) chk("t5_midmove", 32'({floor, moving, hall_dn_pend[6], car_pend[5]}), 32'b010111);
      if (k == 15) chk("t5_reset", 32'({floor, moving, arrive, door_open, hall_up_pend, hall_dn_pend, car_pend}), 32'd0);
    end
    step(1'b0, '0, '0, '0, 1'b0);
    chk("t5_after", 32'({floor, moving, arrive}), 32'd0);

    // Random traffic
    hold_left = 0;
    for (int n = 0; n < 3000; n++) begin
      ru = '0; rd = '0; rc = '0;
      if ($urandom_range(0, 11) == 0) ru[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 11) == 0) rd[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0)  rc[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) rc[m_floor] = 1'b1;
      if (hold_left > 0) begin
        rh = 1'b1;
        hold_left--;
      end else begin
        rh = 1'b0;
        if ($urandom_range(0, 59) == 0) hold_left = $urandom_range(1, 15);
      end
      rr = ($urandom_range(0, 999) == 0);
      step(rr, ru, rd, rc, rh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised single-car elevator controller and the successor of the fixed 7-floor two-way elevator block.
- Generalises the floor count and the travel/door timing, and latches hall-up, hall-down and car requests internally.
- Adds three behaviours: SCAN direction policy with reversal at the current floor, a door-hold/reopen input, and an arrival strobe.
- Sits between the debounced button front-end and the floor/door display logic.

Parameters:
- N_FLOORS, 8, number of floors (0..N_FLOORS-1); must be >= 2.
- MOVE_CYCLES, 10, clock cycles to travel one floor; must be >= 1.
- DOOR_CYCLES, 10, clock cycles the door stays open per service; must be >= 1.
- Local: FW = max(1, $clog2(N_FLOORS)).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- hall_up_req  in  N_FLOORS  up button, bit i = floor i; pulse or level.
- hall_dn_req  in  N_FLOORS  down button, bit i = floor i.
- car_req  in  N_FLOORS  in-car floor buttons.
- door_hold  in  1  keeps the door open while high.
- floor  out  FW  current floor.
- direction  out  2  00 idle, 01 up, 10 down.
- door_open  out  1  door open.
- moving  out  1  car travelling.
- arrive  out  1  one-cycle strobe when the car stops at a floor.
- hall_up_pend, hall_dn_pend, car_pend  out  N_FLOORS each  latched pending requests.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on rising edge of clk.
  - reset is synchronous and active-high.
  - Reset values: floor=0, direction=00, door_open=0, moving=0, arrive=0, all pend=0, FSM=IDLE, timer=0.
  - Reset mid-move or with the door open aborts immediately; there is no partial completion.
- Request latching:
  - Each cycle, pend <= (pend | req) & ~serviced.
  - hall_up bit N_FLOORS-1 and hall_dn bit 0 are masked to 0.
  - A request arriving in the same cycle its bit is serviced is not latched.
- Derived terms (from registered pend):
  - above = any pend bit at index > floor; below = any pend bit at index < floor.
- FSM states: IDLE, MOVING, DOOR_OPEN. moving=1 only in MOVING; door_open=1 only in DOOR_OPEN.
- IDLE, car at floor f:
  - Any request at f: go to DOOR_OPEN and clear car[f].
    - If hall_up[f]: clear it, direction=UP.
    - Else if hall_dn[f]: clear it, direction=DOWN.
    - Else direction=00.
  - Else if above: direction=UP, go to MOVING.
  - Else if below: direction=DOWN, go to MOVING.
  - Else remain in IDLE.
  - Up has priority over down.
  - Latency: a request pulsed at edge t is latched at t; the FSM acts at edge t+1.
- MOVING:
  - Timer is loaded with MOVE_CYCLES on entry.
  - When the timer expires (edge MOVE_CYCLES after entry), floor steps ±1 to g.
  - Stop at g if car[g], or hall_<dir>[g], or there is no request beyond g in the current direction.
  - On stop, on the same edge: arrive=1 for one cycle, enter DOOR_OPEN, clear car[g] and hall_<dir>[g].
    - If nothing is beyond g and only the opposite hall bit is set at g: reverse direction and clear that bit instead.
  - Otherwise reload the timer and continue.
  - floor never goes below 0 or above N_FLOORS-1; the policy guarantees this and the bench asserts it.
- DOOR_OPEN:
  - Timer is loaded with DOOR_CYCLES on entry.
  - door_hold=1 reloads the timer every cycle.
  - A new car[f] or hall_<dir>[f] request at the current floor is absorbed (not latched) and reloads the timer.
  - On expiry:
    - Requests beyond in the current direction: go to MOVING.
    - Else opposite hall bit pending at the current floor: flip direction, clear it, reload the timer, stay in DOOR_OPEN.
    - Else requests in the opposite direction: flip direction, go to MOVING.
    - Else: direction=00, go to IDLE.

Test Plan (N_FLOORS=8, MOVE_CYCLES=10, DOOR_CYCLES=10):
- Reset after 2 cycles -> floor=0, direction=00, door_open=0, moving=0, all pend=0; values hold while reset is high.
- Idle at floor 0, car_req[3] pulse at edge t -> car_pend[3]=1 at t; moving=1 and direction=01 at t+1; floor=1, 2, 3 at t+11, t+21, t+31; arrive high for one cycle at t+31 with door_open=1; door closes at t+41; direction=00 and car_pend=0.
- At floor 0, hall_dn_req[5] and car_req[2] pulsed together -> stops at 2 (arrive, 10-cycle door); continues to 5; direction becomes 10 at floor 5; hall_dn_pend[5] is cleared.
- Door open at floor 3, door_hold high for 25 cycles -> door stays open until 10 cycles after hold falls; a car_req[3] pulse during this time is not latched and reloads the timer.
- Idle at 1, hall_up_req[1] and hall_dn_req[1] together -> door opens with direction=01 and up cleared; at expiry direction=10, dn cleared, door stays open; total open time is 20 cycles; then IDLE.
- reset asserted while moving between floors 2 and 3 -> next edge: floor=0, moving=0, all pend=0, no arrive strobe.
